// File: rtl/bp_be_late_wb_queue_pkg.sv
// Shared types for the late writeback queue.
//  bp_be_wb_pkt_s   : writeback packet carried from the memory / long-latency pipes
//                     to the late regfile write port; the queue passes it through untouched.
//  wb_pkt_width_lp  : flat width of bp_be_wb_pkt_s as seen on the block's ports.
package bp_be_late_wb_queue_pkg;

    typedef struct packed {
        logic        ird_w_v;   // integer regfile write
        logic        frd_w_v;   // fp regfile write
        logic        ptw_w_v;   // page-table-walker fill, routed by the consumer
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
    } bp_be_wb_pkt_s;

    localparam int unsigned wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// Circular packet buffer for the late writeback queue.
//  clk_i, reset_n_i : clock, asynchronous active-low reset
//  enq_v_i/enq_data_i : write a packet at the tail (ignored when full without a dequeue)
//  deq_v_i            : pop the head (ignored when empty)
//  deq_data_o         : current head packet
//  count_o            : occupancy in [0, els_p]
//  full_o / empty_o   : decoded from the registered count
module bp_be_late_wb_fifo
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter int unsigned els_p    = 4,
    parameter int unsigned width_p  = wb_pkt_width_lp,
    localparam int unsigned ptr_w_lp = $clog2(els_p),
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                enq_v_i,
    input  logic [width_p-1:0]  enq_data_i,
    input  logic                deq_v_i,
    output logic [width_p-1:0]  deq_data_o,
    output logic [cnt_w_lp-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                enq_s, deq_s;

    assign full_o     = (count_q == cnt_w_lp'(els_p));
    assign empty_o    = (count_q == {cnt_w_lp{1'b0}});
    assign count_o    = count_q;
    assign deq_data_o = mem_q[rptr_q];

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign deq_s = deq_v_i & ~empty_o;
    assign enq_s = enq_v_i & (~full_o | deq_s);

    // Next-state for pointers and occupancy; pointers wrap because els_p is a power of two.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (deq_s) begin
            rptr_d = rptr_q + ptr_w_lp'(1);
        end else begin
            rptr_d = rptr_q;
        end
        if (enq_s) begin
            wptr_d = wptr_q + ptr_w_lp'(1);
        end else begin
            wptr_d = wptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= {ptr_w_lp{1'b0}};
            wptr_q  <= {ptr_w_lp{1'b0}};
            count_q <= {cnt_w_lp{1'b0}};
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Packet storage; cleared on reset so the head never shows stale data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= {width_p{1'b0}};
            end
        end else if (enq_s) begin
            mem_q[wptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/bp_be_late_wb_queue_sva.sv
// Protocol checker for the late writeback queue.
//  late_wb_yumi_i must only be raised while late_wb_v_i is high.
//  A memory packet may only be dropped after issue was already told to hold
//  (credits_full_i high the cycle before), i.e. never under credit-respecting stimulus.
module bp_be_late_wb_queue_sva (
    input logic clk_i,
    input logic reset_n_i,
    input logic late_wb_v_i,
    input logic late_wb_yumi_i,
    input logic mem_drop_i,
    input logic credits_full_i
);

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        late_wb_yumi_i |-> late_wb_v_i);

    a_drop_only_after_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_drop_i |-> $past(credits_full_i));

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// Late writeback queue: buffers memory-pipe late writebacks and arbitrates them with
// long-latency pipe writebacks onto the single late regfile write port.
//  clk_i, reset_n_i      : clock, asynchronous active-low reset
//  mem_wb_pkt_i/_v_i     : memory pipe packet, no backpressure (always accepted if room)
//  long_wb_pkt_i/_v_i    : long-latency pipe packet
//  long_wb_ready_and_o   : long packet consumed this cycle
//  late_wb_pkt_o/_v_o    : selected packet to the regfile
//  late_wb_yumi_i        : regfile consumed late_wb_pkt_o
//  credits_full_o        : issue must hold new memory ops
//  empty_o               : queue holds no packets
//  overflow_o            : sticky, a memory packet was dropped
module bp_be_late_wb_queue
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter int unsigned els_p          = 4,
    parameter int unsigned credit_slack_p = 2,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [wb_pkt_width_lp-1:0] mem_wb_pkt_i,
    input  logic                       mem_wb_v_i,
    input  logic [wb_pkt_width_lp-1:0] long_wb_pkt_i,
    input  logic                       long_wb_v_i,
    output logic                       long_wb_ready_and_o,
    output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
    output logic                       late_wb_v_o,
    input  logic                       late_wb_yumi_i,
    output logic                       credits_full_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int unsigned cnt_w_lp    = $clog2(els_p + 1);
    localparam int unsigned starve_w_lp = $clog2(starve_limit_p + 1);

    logic [wb_pkt_width_lp-1:0] head_pkt_s;
    logic [cnt_w_lp-1:0]        count_s;
    logic                       fifo_full_s, fifo_empty_s;
    logic                       sel_long_s, deq_s, enq_s, drop_s, long_ready_s;
    logic [starve_w_lp-1:0]     starve_cnt_q, starve_cnt_d;
    logic                       overflow_q, overflow_d;

    // The long pipe wins when nothing is buffered, or once it has waited starve_limit_p cycles.
    assign sel_long_s   = long_wb_v_i
                        & (fifo_empty_s | (starve_cnt_q == starve_w_lp'(starve_limit_p)));
    assign deq_s        = late_wb_yumi_i & ~sel_long_s & ~fifo_empty_s;
    // Held low during reset so the long pipe never sees a handshake it cannot rely on.
    assign long_ready_s = reset_n_i & late_wb_yumi_i & sel_long_s;
    assign enq_s        = mem_wb_v_i & (~fifo_full_s | deq_s);
    assign drop_s       = mem_wb_v_i & fifo_full_s & ~deq_s;

    assign long_wb_ready_and_o = long_ready_s;
    assign late_wb_v_o         = ~fifo_empty_s | long_wb_v_i;
    assign empty_o             = fifo_empty_s;
    assign credits_full_o      = (count_s >= cnt_w_lp'(els_p - credit_slack_p));
    assign overflow_o          = overflow_q;

    bp_be_late_wb_fifo #(
        .els_p   (els_p),
        .width_p (wb_pkt_width_lp)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (enq_s),
        .enq_data_i (mem_wb_pkt_i),
        .deq_v_i    (deq_s),
        .deq_data_o (head_pkt_s),
        .count_o    (count_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s)
    );

    // Output packet mux.
    always_comb begin
        late_wb_pkt_o = head_pkt_s;
        if (sel_long_s) begin
            late_wb_pkt_o = long_wb_pkt_i;
        end else begin
            late_wb_pkt_o = head_pkt_s;
        end
    end

    // Starvation counter (saturating) and sticky overflow next-state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        overflow_d   = overflow_q | drop_s;
        if (!long_wb_v_i || long_ready_s) begin
            starve_cnt_d = {starve_w_lp{1'b0}};
        end else if (starve_cnt_q != starve_w_lp'(starve_limit_p)) begin
            starve_cnt_d = starve_cnt_q + starve_w_lp'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_q <= {starve_w_lp{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    bp_be_late_wb_queue_sva u_sva (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .late_wb_v_i    (late_wb_v_o),
        .late_wb_yumi_i (late_wb_yumi_i),
        .mem_drop_i     (drop_s),
        .credits_full_i (credits_full_o)
    );

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
module tb_bp_be_late_wb_queue;
    import bp_be_late_wb_queue_pkg::*;

    typedef struct {
        logic [wb_pkt_width_lp-1:0] pkt;
        logic                       is_long;
    } exp_t;

    logic                       clk_i = 1'b0;
    logic                       reset_n_i;
    logic [wb_pkt_width_lp-1:0] mem_wb_pkt_i;
    logic                       mem_wb_v_i;
    logic [wb_pkt_width_lp-1:0] long_wb_pkt_i;
    logic                       long_wb_v_i;
    logic                       long_wb_ready_and_o;
    logic [wb_pkt_width_lp-1:0] late_wb_pkt_o;
    logic                       late_wb_v_o;
    logic                       late_wb_yumi_i;
    logic                       credits_full_o;
    logic                       empty_o;
    logic                       overflow_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    bp_be_late_wb_queue #(
        .els_p          (4),
        .credit_slack_p (2),
        .starve_limit_p (8)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .mem_wb_pkt_i        (mem_wb_pkt_i),
        .mem_wb_v_i          (mem_wb_v_i),
        .long_wb_pkt_i       (long_wb_pkt_i),
        .long_wb_v_i         (long_wb_v_i),
        .long_wb_ready_and_o (long_wb_ready_and_o),
        .late_wb_pkt_o       (late_wb_pkt_o),
        .late_wb_v_o         (late_wb_v_o),
        .late_wb_yumi_i      (late_wb_yumi_i),
        .credits_full_o      (credits_full_o),
        .empty_o             (empty_o),
        .overflow_o          (overflow_o)
    );

    function automatic logic [wb_pkt_width_lp-1:0] mk(input int rd, input logic ptw);
        bp_be_wb_pkt_s p;
        p.ird_w_v = ~ptw;
        p.frd_w_v = 1'b0;
        p.ptw_w_v = ptw;
        p.rd_addr = rd[4:0];
        p.rd_data = 64'hC0DE_0000_0000_0000 | 64'(rd);
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int rd, input logic is_long);
        exp_t e;
        e.pkt     = mk(rd, is_long);
        e.is_long = is_long;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic mv, input int rd, input logic y);
        mem_wb_v_i     = mv;
        mem_wb_pkt_i   = mk(rd, 1'b0);
        late_wb_yumi_i = y;
    endtask

    task automatic drive_long(input logic lv, input int rd);
        long_wb_v_i   = lv;
        long_wb_pkt_i = mk(rd, 1'b1);
    endtask

    // Monitor: every accepted output is compared with the next expected packet.
    always @(negedge clk_i) begin
        if (reset_n_i && late_wb_yumi_i) begin
            if (!late_wb_v_o) begin
                chk("yumi_with_valid", late_wb_v_o, 1'b1);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_output", late_wb_pkt_o, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pkt", late_wb_pkt_o, mon_e.pkt);
                chk("long_ready", long_wb_ready_and_o, mon_e.is_long);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state; long input is combinationally visible but never handshaken.
        reset_n_i = 1'b0;
        drive(1'b0, 0, 1'b1);
        drive_long(1'b1, 50);
        #2;
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_credits", credits_full_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_late_v_long", late_wb_v_o, 1'b1);
        chk("rst_long_ready", long_wb_ready_and_o, 1'b0);
        #10;
        drive(1'b0, 0, 1'b0);
        drive_long(1'b0, 0);
        reset_n_i = 1'b1;

        // Ordering: rd 5,6,7 back to back, one-cycle latency.
        tick();
        push(5, 1'b0); push(6, 1'b0); push(7, 1'b0);
        drive(1'b1, 5, 1'b0);
        #1 chk("no_bypass_v", late_wb_v_o, 1'b0);
        tick(); drive(1'b1, 6, 1'b1);
        tick(); drive(1'b1, 7, 1'b1);
        tick(); drive(1'b0, 0, 1'b1);
        tick(); drive(1'b0, 0, 1'b0);
        chk("order_empty", empty_o, 1'b1);

        // Reset mid-stream with three packets queued.
        drive(1'b1, 1, 1'b0);
        tick(); drive(1'b1, 2, 1'b0);
        tick(); drive(1'b1, 3, 1'b0);
        tick(); drive(1'b0, 0, 1'b0);
        chk("three_credits", credits_full_o, 1'b1);
        chk("three_empty", empty_o, 1'b0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("midrst_empty", empty_o, 1'b1);
        chk("midrst_late_v", late_wb_v_o, 1'b0);
        chk("midrst_overflow", overflow_o, 1'b0);
        chk("midrst_credits", credits_full_o, 1'b0);
        #1 reset_n_i = 1'b1;

        // Fill to full, overflow with a fifth packet, then drain.
        tick(); drive(1'b1, 10, 1'b0);
        tick(); chk("cnt1_credits", credits_full_o, 1'b0); drive(1'b1, 11, 1'b0);
        tick(); chk("cnt2_credits", credits_full_o, 1'b1); drive(1'b1, 12, 1'b0);
        tick(); drive(1'b1, 13, 1'b0);
        tick(); chk("cnt4_no_ovf", overflow_o, 1'b0); drive(1'b1, 14, 1'b0);
        tick();
        chk("ovf_set", overflow_o, 1'b1);
        chk("ovf_credits", credits_full_o, 1'b1);
        for (int i = 10; i < 14; i++) push(i, 1'b0);
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        tick(); drive(1'b0, 0, 1'b0);
        chk("drain_empty", empty_o, 1'b1);
        chk("ovf_sticky", overflow_o, 1'b1);
        #1 reset_n_i = 1'b0;
        #1 chk("ovf_cleared", overflow_o, 1'b0);
        reset_n_i = 1'b1;

        // Wrap plus simultaneous enqueue/dequeue while full.
        for (int i = 20; i < 26; i++) push(i, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); drive(1'b1, 20 + i, 1'b0);
        end
        tick(); chk("full_credits", credits_full_o, 1'b1); drive(1'b1, 24, 1'b1);
        tick();
        chk("enqdeq_ovf", overflow_o, 1'b0);
        chk("enqdeq_credits", credits_full_o, 1'b1);
        drive(1'b1, 25, 1'b1);
        tick();
        chk("enqdeq2_ovf", overflow_o, 1'b0);
        chk("enqdeq2_empty", empty_o, 1'b0);
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        tick(); drive(1'b0, 0, 1'b0);
        chk("wrap_empty", empty_o, 1'b1);

        // Starvation: long waits 8 cycles against a mem stream, wins on the 9th.
        for (int i = 30; i < 38; i++) push(i, 1'b0);
        push(40, 1'b1); push(38, 1'b0); push(39, 1'b0); push(41, 1'b1);
        drive(1'b1, 30, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick(); drive(1'b1, 30 + k, 1'b1); drive_long(1'b1, 40);
        end
        tick(); drive(1'b1, 39, 1'b1);
        // Counter must be back to 0: buffered packets win again over a new long request.
        tick(); drive(1'b0, 0, 1'b1); drive_long(1'b1, 41);
        tick();
        // Queue empty: long passes in the same cycle.
        tick();
        #1 chk("empty_long_ready", long_wb_ready_and_o, 1'b1);
        tick(); drive(1'b0, 0, 1'b0); drive_long(1'b0, 0);
        chk("final_empty", empty_o, 1'b1);
        #1 chk("final_late_v", late_wb_v_o, 1'b0);

        tick();
        chk("exp_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
